// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment display driver.
package seg_pkg;

    // Active-low cathode vector, bit0 = a ... bit6 = g
    typedef logic [6:0] seg_t;

    // All segments dark
    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low hex glyphs, written g..a
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t pattern;
        case (nibble)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low segment mapper.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed seven-segment scanner with per-digit blank/blink/dp,
// global PWM brightness and a once-per-frame shadow copy of all inputs.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 25000,
    parameter int BLINK_DIV  = 50_000_000,
    parameter int PWM_BITS   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [PWM_BITS-1:0]     brightness,
    output seg_t                    seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]       scnt;
    logic [IDX_W-1:0]        idx;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    phase;
    logic [PWM_BITS-1:0]     pwm_cnt;

    logic [4*NUM_DIGITS-1:0] digits_s;
    logic [NUM_DIGITS-1:0]   dp_s;
    logic [NUM_DIGITS-1:0]   blank_mask_s;
    logic [NUM_DIGITS-1:0]   blink_mask_s;
    logic [PWM_BITS-1:0]     brightness_s;

    logic                    tick;
    logic                    frame_start;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_blink;
    logic                    vis;
    seg_t                    cur_seg;
    logic [NUM_DIGITS-1:0]   an_next;

    assign tick        = (scnt == SCAN_LAST);
    assign frame_start = tick && (idx == IDX_LAST);

    // Slot timer and digit index; idx starts on the last digit so the first tick is a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            idx  <= IDX_LAST;
        end else if (tick) begin
            scnt <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    // Blink half-period timer; the phase bit flips each time it wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Free-running PWM ramp, compared against the captured brightness
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Shadow copy of every display input, refreshed only at frame start so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_s     <= '0;
            dp_s         <= '0;
            blank_mask_s <= '1;
            blink_mask_s <= '0;
            brightness_s <= '0;
        end else if (frame_start) begin
            digits_s     <= digits;
            dp_s         <= dp;
            blank_mask_s <= blank_mask;
            blink_mask_s <= blink_mask;
            brightness_s <= brightness;
        end
    end

    // Pick out the active digit's shadow fields and decide whether it is lit this cycle
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b1;
        cur_blink  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = digits_s[4*i +: 4];
                cur_dp     = dp_s[i];
                cur_blank  = blank_mask_s[i];
                cur_blink  = blink_mask_s[i];
            end
        end
        vis = !cur_blank && !(cur_blink && phase) && (pwm_cnt <= brightness_s);
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (vis && (idx == IDX_W'(i))) begin
                an_next[i] = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Registered pin drivers so the board sees glitch-free anodes and cathodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= '1;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_next;
            seg  <= vis ? cur_seg : SEG_OFF;
            dp_n <= vis ? ~cur_dp : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: a cycle-number model of the scanned display
// checked every cycle, plus literal expectations at chosen cycles.
module tb_seg_display_scanner;

    localparam int N = 4;
    localparam int S = 4;
    localparam int B = 64;
    localparam int P = 2;

    localparam logic [6:0] DEC_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
    } out_t;

    localparam out_t DARK = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1};

    logic         clk;
    logic         rst_n;
    logic [15:0]  digits;
    logic [3:0]   dp;
    logic [3:0]   blank_mask;
    logic [3:0]   blink_mask;
    logic [1:0]   brightness;
    logic [6:0]   seg;
    logic         dp_n;
    logic [3:0]   an;

    int errors = 0;
    int checks = 0;

    // Model state: edges seen since reset release and the frame-captured inputs
    int           m_n;
    logic [15:0]  sh_digits;
    logic [3:0]   sh_dp;
    logic [3:0]   sh_blank;
    logic [3:0]   sh_blink;
    logic [1:0]   sh_bright;
    out_t         exp_o;

    seg_display_scanner #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .BLINK_DIV  (B),
        .PWM_BITS   (P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp         (dp),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the pins must show given the state reached after edge n
    function automatic out_t model_out(input int n, input logic [15:0] d, input logic [3:0] dpm,
                                       input logic [3:0] blank, input logic [3:0] blink,
                                       input logic [1:0] br);
        int   k;
        int   pwm;
        int   ph;
        logic lit;
        out_t o;
        k   = (N - 1 + n / S) % N;
        pwm = n % (1 << P);
        ph  = (n / B) % 2;
        lit = !blank[k] && !(blink[k] && ph == 1) && (pwm <= int'(br));
        o = DARK;
        if (lit) begin
            o.an[k] = 1'b0;
            o.seg   = DEC_TAB[d[k*4 +: 4]];
            o.dp_n  = !dpm[k];
        end
        return o;
    endfunction

    // A frame starts on every N*S-th edge, the first one S edges after release
    function automatic bit is_frame_edge(input int e);
        return (e >= S) && ((e - S) % (N * S) == 0);
    endfunction

    // Model advance: outputs lag the state by one edge, inputs captured only on frame edges
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n       <= 0;
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            sh_blink  <= '0;
            sh_bright <= '0;
            exp_o     <= DARK;
        end else begin
            exp_o <= model_out(m_n, sh_digits, sh_dp, sh_blank, sh_blink, sh_bright);
            m_n   <= m_n + 1;
            if (is_frame_edge(m_n + 1)) begin
                sh_digits <= digits;
                sh_dp     <= dp;
                sh_blank  <= blank_mask;
                sh_blink  <= blink_mask;
                sh_bright <= brightness;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] blank,
                                 input logic [3:0] blink, input logic [1:0] br);
        digits     = d;
        dp         = dpm;
        blank_mask = blank;
        blink_mask = blink;
        brightness = br;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                               input logic e_dp);
        checks++;
        if (an !== e_an || seg !== e_seg || dp_n !== e_dp) begin
            errors++;
            $display("[TB] FAIL %s: got an=%b seg=%b dp_n=%b, expected an=%b seg=%b dp_n=%b",
                     name, an, seg, dp_n, e_an, e_seg, e_dp);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One clock step, then compare the pins with the model and the one-hot-low anode rule
    task automatic stepCycle();
        @(negedge clk);
        if (rst_n) begin
            checks++;
            if (an !== exp_o.an || seg !== exp_o.seg || dp_n !== exp_o.dp_n) begin
                errors++;
                $display("[TB] FAIL model cycle %0d: got an=%b seg=%b dp_n=%b, expected an=%b seg=%b dp_n=%b",
                         m_n, an, seg, dp_n, exp_o.an, exp_o.seg, exp_o.dp_n);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("[TB] FAIL anode onehot cycle %0d: got an=%b, expected at most one low", m_n, an);
            end
        end
    endtask

    task automatic waitCycle(input int t);
        while (m_n < t) stepCycle();
    endtask

    int lows [4];

    initial begin
        rst_n = 1'b0;
        applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset: dark until the first frame start, digit 0 shows at cycle 5
        checkOutput("reset cycle 0", 4'hF, 7'h7F, 1'b1);
        for (int t = 1; t <= 4; t++) begin
            waitCycle(t);
            checkOutput($sformatf("reset cycle %0d", t), 4'hF, 7'h7F, 1'b1);
        end

        // Static value 1234 across the first frame
        waitCycle(5);
        checkOutput("static digit0", 4'b1110, 7'b0011001, 1'b1);
        waitCycle(9);
        checkOutput("static digit1", 4'b1101, 7'b0110000, 1'b1);

        // Tear-free: new value mid-frame must wait for the next frame start
        waitCycle(10);
        applyStimulus(16'hABCD, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        waitCycle(13);
        checkOutput("static digit2", 4'b1011, 7'b0100100, 1'b1);
        waitCycle(17);
        checkOutput("tearfree old digit3", 4'b0111, 7'b1111001, 1'b1);
        waitCycle(21);
        checkOutput("tearfree new digit0", 4'b1110, 7'b0100001, 1'b1);
        waitCycle(25);
        checkOutput("tearfree new digit1", 4'b1101, 7'b1000110, 1'b1);

        // Blink digits 0 and 1; phase 1 covers cycles 65..128
        waitCycle(22);
        applyStimulus(16'hABCD, 4'b0000, 4'b0000, 4'b0011, 2'd3);
        waitCycle(69);
        checkOutput("blink off digit0", 4'hF, 7'h7F, 1'b1);
        waitCycle(73);
        checkOutput("blink off digit1", 4'hF, 7'h7F, 1'b1);
        waitCycle(77);
        checkOutput("blink keeps digit2", 4'b1011, 7'b0000011, 1'b1);
        waitCycle(81);
        checkOutput("blink keeps digit3", 4'b0111, 7'b0001000, 1'b1);
        waitCycle(133);
        checkOutput("blink back digit0", 4'b1110, 7'b0100001, 1'b1);

        // Minimum brightness with dp on digit 2, captured at edge 148
        waitCycle(137);
        applyStimulus(16'hABCD, 4'b0100, 4'b0000, 4'b0000, 2'd0);
        waitCycle(148);
        for (int b = 0; b < 4; b++) lows[b] = 0;
        for (int t = 149; t <= 164; t++) begin
            waitCycle(t);
            for (int b = 0; b < 4; b++) if (!an[b]) lows[b]++;
            if (t == 157) checkOutput("pwm digit2 lit with dp", 4'b1011, 7'b0000011, 1'b0);
            if (t == 158) checkOutput("pwm digit2 dark", 4'hF, 7'h7F, 1'b1);
            if (t == 161) applyStimulus(16'hABCD, 4'b0100, 4'b0000, 4'b0000, 2'd3);
        end
        for (int b = 0; b < 4; b++) checkCount($sformatf("pwm lit cycles an[%0d]", b), lows[b], 1);

        // Async reset between edges while a digit is lit
        waitCycle(170);
        checkOutput("before async reset", 4'b1101, 7'b1000110, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset immediate", 4'hF, 7'h7F, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("held in reset", 4'hF, 7'h7F, 1'b1);
        rst_n = 1'b1;
        waitCycle(4);
        checkOutput("after reset still dark", 4'hF, 7'h7F, 1'b1);
        waitCycle(5);
        checkOutput("after reset digit0", 4'b1110, 7'b0100001, 1'b1);
        waitCycle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

- Parametrised, time-multiplexed seven-segment driver for the board display. It runs entirely in the system clock domain and generates its scan, blink and brightness timing internally from divider parameters; it needs no external slow clocks.
- It supports N digits, per-digit blanking, blinking and decimal points, and global PWM brightness.
- All display inputs are captured into a shadow register once per frame, so a digit update never tears.
- It sits between the timer/clock logic, which supplies hex digits, and the board pins.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits; must be ≥ 1.
- `SCAN_DIV`, 25000: clock cycles per digit slot; must be ≥ 2 and a multiple of 2^`PWM_BITS`.
- `BLINK_DIV`, 50_000_000: clock cycles per blink half-period.
- `PWM_BITS`, 3: brightness resolution.
- `clk`, in, 1: system clock. One clock only.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `digits`, in, 4·`NUM_DIGITS`: hex nibbles. Nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost.
- `dp`, in, `NUM_DIGITS`: decimal point request per digit, 1 = lit.
- `blank_mask`, in, `NUM_DIGITS`: 1 = digit permanently dark.
- `blink_mask`, in, `NUM_DIGITS`: 1 = digit dark during the blink-off phase.
- `brightness`, in, `PWM_BITS`: duty is (`brightness`+1)/2^`PWM_BITS`.
- `seg`, out, 7: cathodes, active-low, bit0 = a … bit6 = g.
- `dp_n`, out, 1: decimal point cathode, active-low.
- `an`, out, `NUM_DIGITS`: anodes, active-low, `an[i]` selects digit i.

## Operation
- **Scan counter** `scnt` counts 0…`SCAN_DIV`−1 and wraps.
  - The tick asserts when `scnt` == `SCAN_DIV`−1.
  - On a tick, digit index `idx` advances by one and wraps from `NUM_DIGITS`−1 to 0.
- **Frame start** is a tick with `idx` == `NUM_DIGITS`−1. On that edge the shadow register loads `digits`, `dp`, `blank_mask`, `blink_mask` and `brightness`.
  - Inputs are ignored between frame starts.
- **Blink counter** counts 0…`BLINK_DIV`−1. On wrap, the phase bit toggles: 0 = visible, 1 = blink-off.
- **PWM counter** is free-running, 2^`PWM_BITS` states, and increments every cycle.
- **Digit visibility:** `vis` = NOT `blank_mask_s[idx]` AND NOT (`blink_mask_s[idx]` AND phase) AND (`pwm` ≤ `brightness_s`).
- **Registered outputs**, updated every cycle:
  - `an` is all ones except bit `idx`, which is low when `vis`.
  - `seg` = decode(`digits_s[idx]`) when `vis`, else 7'h7F.
  - `dp_n` = NOT `dp_s[idx]` when `vis`, else 1.
- **Decode** (active-low, g…a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- **Reset values:**
  - Outputs: `an` all ones, `seg` 7'h7F, `dp_n` 1.
  - Counters: `scnt`, blink counter, phase and PWM counter all 0.
  - `idx` = `NUM_DIGITS`−1.
  - Shadow: all fields 0, except `blank_mask_s` all ones.
  - Consequence: the display stays dark until the first frame start.
- **Boundary behaviour:**
  - Reset asserted mid-frame forces all reset values immediately, without waiting for `clk`.
  - If a blink toggle and a frame start fall on the same edge, both take effect; the new digit uses the new phase.
  - With `NUM_DIGITS` = 1, `idx` is 1 bit wide and stays 0; every tick is a frame start.
  - With `brightness` at maximum, the digit is lit for the whole slot.

## Timing
- **Output latency:** one cycle from any `idx`, phase or PWM change to `an`/`seg`/`dp_n`.
- **First digit** (digit 0) appears `SCAN_DIV`+1 cycles after `rst_n` deasserts.
- **Input-to-display latency:** at most `NUM_DIGITS`·`SCAN_DIV`+1 cycles from an input change to the display.
- **Anodes:** at most one `an` bit is low in any cycle.
- **Full frame:** `NUM_DIGITS`·`SCAN_DIV` cycles.
- **Blink period:** 2·`BLINK_DIV` cycles.

## Structure
- **Package `seg_pkg`:**
  - `SEG_OFF` = 7'h7F.
  - A typedef for the 7-bit segment vector.
  - The hex decode table as a function.
- **Sub-module `seg7_decode`:** a combinational nibble → active-low segment mapper. It is instantiated once, on the muxed nibble.
- **Top level** holds the three counters, the `idx` register, the shadow register and the output registers.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `SCAN_DIV`=4, `BLINK_DIV`=64, `PWM_BITS`=2.

1. **Reset:** release `rst_n`. Required: `an`=4'hF, `seg`=7'h7F and `dp_n`=1 for cycles 0–4; at cycle 5, `an`=4'b1110.
2. **Static value:** `digits`=16'h1234, `brightness`=3, masks 0. Over one frame, required:
   - `an`=1110 with `seg`=0011001 (digit 4)
   - `an`=1101 with `seg`=0110000 (digit 3)
   - `an`=1011 with `seg`=0100100 (digit 2)
   - `an`=0111 with `seg`=1111001 (digit 1)
3. **Tear-free update:** change `digits` mid-frame. Required: the old value completes the frame; the new value appears from the next frame start.
4. **Blink:** `blink_mask`=4'b0011. Required:
   - During phase 1, `an[1:0]` stay high and `seg`=7'h7F on those slots.
   - `an[3:2]` are unaffected.
   - After 64 more cycles all four digits are visible again.
5. **PWM:** `brightness`=0. Required: each `an` bit is low for exactly 1 of its 4 slot cycles. `dp`=4'b0100 gives `dp_n`=0 only while `an[2]` is low.
6. **Async reset mid-scan:** assert `rst_n`=0 between clock edges. Required: `an`=4'hF, `seg`=7'h7F and `dp_n`=1 immediately, without waiting for a clock edge.
